multi_window_display: RTL and testbench
=======================================

Name: multi_window_display

Overview:
- Successor of the single/dual picture overlay: composites up to NUM_WIN image windows from one shared external synchronous image ROM onto a BACK_COLOR background.
- Per-window runtime position, enable and pixel mode: raw, grey, invert or threshold.
- Sits between the timing generator (act_x/act_y/syncs) and the HDMI encoder.
- Syncs are delayed to match the full pixel pipeline.

Parameters:
- COLOR_DEPTH, 8, bits per channel; pixel width 3*COLOR_DEPTH, R in MSBs.
- X_BITS, 12, x coordinate width.
- Y_BITS, 12, y coordinate width.
- NUM_WIN, 2, number of windows, 1..4; window 0 has highest priority.
- PIC_W, 256, window/image width in pixels, common to all windows.
- PIC_H, 256, window/image height in pixels.
- ADDR_BITS, 18, ROM address width; must hold NUM_WIN*PIC_W*PIC_H.
- ROM_LAT, 1, ROM read latency in cycles, 1..3.
- BACK_COLOR, 24'hE0FFFF, background pixel.
- BORDER_COLOR, 24'hFF0000, border pixel (optional feature only).

Ports:
- pix_clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- act_x  in  X_BITS  active x, aligned with de_in.
- act_y  in  Y_BITS  active y.
- vs_in  in  1  vertical sync.
- hs_in  in  1  horizontal sync.
- de_in  in  1  data enable.
- win_x  in  NUM_WIN*X_BITS  window left x; window i in slice i.
- win_y  in  NUM_WIN*Y_BITS  window top y.
- win_en  in  NUM_WIN  window enable.
- win_mode  in  NUM_WIN*2  per window: 0 raw, 1 grey, 2 invert, 3 threshold.
- thresh  in  COLOR_DEPTH  threshold level for mode 3.
- rom_addr  out  ADDR_BITS  registered ROM read address.
- rom_data  in  3*COLOR_DEPTH  ROM data, valid ROM_LAT cycles after rom_addr.
- vs_out  out  1  delayed vs.
- hs_out  out  1  delayed hs.
- de_out  out  1  delayed de.
- pixel_data  out  3*COLOR_DEPTH  composited pixel.

Behaviour:
- Reset:
  - pixel_data = BACK_COLOR.
  - vs_out/hs_out/de_out = 0, rom_addr = 0.
  - All counters and pipeline cleared; shadow config cleared, so all windows are disabled.
- Shadow config:
  - On a vs_in rising edge (previous-cycle register), latch win_x, win_y, win_en, win_mode and thresh into shadow registers and clear every window address counter.
  - Mid-frame input changes have no effect until the next frame.
  - Reset mid-frame gives background output until the first vs rising edge after reset release.
- Hit:
  - hit_i = shadow_en_i && de_in && act_x in [x_i, x_i+PIC_W) && act_y in [y_i, y_i+PIC_H).
  - Comparisons are done at X_BITS+1 / Y_BITS+1 width, so window extents beyond the coordinate range never wrap.
- Counters:
  - cnt_i increments on every hit_i, including when window i is occluded, so each image stays intact.
  - cnt_i wraps to 0 after PIC_W*PIC_H-1.
- Address:
  - Select the lowest i with hit_i.
  - rom_addr <= i*PIC_W*PIC_H + cnt_i; with no hit, rom_addr holds 0.
  - The hit flag, selected index and mode go down a ROM_LAT-deep side pipeline.
- Process stage P1:
  - Register rom_data.
  - Compute R*77, G*150 and B*29 in separate multiplies.
- Process stage P2:
  - Y = (sum)>>8, truncated to COLOR_DEPTH.
  - Mode 0: raw. Mode 1: {Y,Y,Y}. Mode 2: bitwise NOT of raw. Mode 3: all-ones if Y >= thresh, else 0.
  - No hit: BACK_COLOR.
- Output: pixel_data registered after P2.
- Latency:
  - Total LAT = ROM_LAT + 3 cycles from act_x/act_y/de_in to pixel_data.
  - vs/hs/de are delayed by exactly LAT through a shift register; there is no extra output stage beyond that.
- Boundaries:
  - Overlapping windows: lowest index is displayed.
  - Windows with identical position: only window 0 is visible.
  - de_in low always yields BACK_COLOR.

Optional Feature:
- Macro: MULTI_WIN_BORDER_EN.
- Defined:
  - Pixels on the outermost ring of an enabled, topmost window are replaced by BORDER_COLOR at the output stage: x == x_i, x == x_i+PIC_W-1, y == y_i or y == y_i+PIC_H-1.
  - Counters and addresses are unaffected.
  - The border flag is carried in the side pipeline.
- Undefined: no border logic; the output is the pure image.

Test Plan:
- Reset, then one frame with win_en=0 -> every de_out-high pixel = 24'hE0FFFF; rom_addr stays 0; syncs delayed by exactly ROM_LAT+3.
- Window 0 at (640,412), mode 0, ROM data = address -> pixel at (640,412) = 0 and (895,667) = 65535, LAT cycles after input; (639,412) = BACK_COLOR.
- Window 1 mode 1, rom_data 24'hFF0000 -> output 24'h4C4C4C; mode 2 gives 24'h00FFFF; mode 3 with thresh 8'h50 gives 24'h000000, with thresh 8'h4C gives 24'hFFFFFF.
- Windows 0 and 1 both at (100,100) -> window-0 data shown; window-1 cnt still reaches PIC_W*PIC_H, and rom_addr base for window 1 = 65536 when it is moved clear next frame.
- Change win_x mid-frame -> current frame unchanged; next frame shifted; assert rst mid-line -> outputs at reset values immediately, background until the next vs edge.
- With MULTI_WIN_BORDER_EN: window at (10,10) -> (10,10..265) and (265,y) = BORDER_COLOR; (11,11) = image data.

Source files
------------

// File: rtl/multi_window_display.sv
// Composites NUM_WIN image windows, all read from one shared synchronous ROM, over BACK_COLOR.
// Defining MULTI_WIN_BORDER_EN outlines the topmost window's outer ring in BORDER_COLOR.
module multi_window_display #(
  parameter int COLOR_DEPTH = 8,
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int NUM_WIN = 2,
  parameter int PIC_W = 256,
  parameter int PIC_H = 256,
  parameter int ADDR_BITS = 18,
  parameter int ROM_LAT = 1,
  parameter logic [3*COLOR_DEPTH-1:0] BACK_COLOR = 24'hE0FFFF
`ifdef MULTI_WIN_BORDER_EN
  ,
  parameter logic [3*COLOR_DEPTH-1:0] BORDER_COLOR = 24'hFF0000
`endif
) (
  input  logic                        pix_clk,
  input  logic                        rst,
  input  logic [X_BITS-1:0]           act_x,
  input  logic [Y_BITS-1:0]           act_y,
  input  logic                        vs_in,
  input  logic                        hs_in,
  input  logic                        de_in,
  input  logic [NUM_WIN*X_BITS-1:0]   win_x,
  input  logic [NUM_WIN*Y_BITS-1:0]   win_y,
  input  logic [NUM_WIN-1:0]          win_en,
  input  logic [NUM_WIN*2-1:0]        win_mode,
  input  logic [COLOR_DEPTH-1:0]      thresh,
  output logic [ADDR_BITS-1:0]        rom_addr,
  input  logic [3*COLOR_DEPTH-1:0]    rom_data,
  output logic                        vs_out,
  output logic                        hs_out,
  output logic                        de_out,
  output logic [3*COLOR_DEPTH-1:0]    pixel_data
);

  localparam int PIX_W = 3 * COLOR_DEPTH;
  localparam int PIC_N = PIC_W * PIC_H;
  localparam int CNT_BITS = (PIC_N > 1) ? $clog2(PIC_N) : 1;
  localparam int LAT = ROM_LAT + 3;
  localparam logic [X_BITS:0] SPAN_X = (X_BITS+1)'(PIC_W);
  localparam logic [Y_BITS:0] SPAN_Y = (Y_BITS+1)'(PIC_H);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(PIC_N - 1);

  logic [X_BITS-1:0]      sh_x [NUM_WIN];
  logic [Y_BITS-1:0]      sh_y [NUM_WIN];
  logic [1:0]             sh_mode [NUM_WIN];
  logic [NUM_WIN-1:0]     sh_en;
  logic [COLOR_DEPTH-1:0] sh_thresh;
  logic                   vs_prev;
  logic                   vs_rise;

  logic [CNT_BITS-1:0]    cnt [NUM_WIN];
  logic [NUM_WIN-1:0]     hit;
  logic                   sel_hit;
  logic [1:0]             sel_mode;
  logic [ADDR_BITS-1:0]   sel_addr;

  logic                   s_hit [ROM_LAT+1];
  logic [1:0]             s_mode [ROM_LAT+1];

  logic                   p1_hit;
  logic [1:0]             p1_mode;
  logic [PIX_W-1:0]       p1_data;
  logic [COLOR_DEPTH+7:0] p1_r, p1_g, p1_b;
  logic [COLOR_DEPTH+7:0] luma_sum;
  logic [COLOR_DEPTH-1:0] luma;
  logic [PIX_W-1:0]       proc_pix;

  logic [2:0]             sync_pipe [LAT];

`ifdef MULTI_WIN_BORDER_EN
  localparam logic [X_BITS:0] LAST_X = (X_BITS+1)'(PIC_W - 1);
  localparam logic [Y_BITS:0] LAST_Y = (Y_BITS+1)'(PIC_H - 1);
  logic [NUM_WIN-1:0] ring;
  logic               sel_ring;
  logic               s_ring [ROM_LAT+1];
  logic               p1_ring;
`endif

  assign vs_rise = vs_in && !vs_prev;

  // Window configuration is frozen per frame; it only changes at the start of vertical sync.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vs_prev   <= 1'b0;
      sh_en     <= '0;
      sh_thresh <= '0;
      for (int i = 0; i < NUM_WIN; i++) begin
        sh_x[i]    <= '0;
        sh_y[i]    <= '0;
        sh_mode[i] <= '0;
      end
    end else begin
      vs_prev <= vs_in;
      if (vs_rise) begin
        sh_en     <= win_en;
        sh_thresh <= thresh;
        for (int i = 0; i < NUM_WIN; i++) begin
          sh_x[i]    <= win_x[i*X_BITS +: X_BITS];
          sh_y[i]    <= win_y[i*Y_BITS +: Y_BITS];
          sh_mode[i] <= win_mode[i*2 +: 2];
        end
      end
    end
  end

  // Extended-width compares keep windows hanging off the screen edge from wrapping around.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      hit[i] = sh_en[i] && de_in
               && ({1'b0, act_x} >= {1'b0, sh_x[i]})
               && ({1'b0, act_x} <  ({1'b0, sh_x[i]} + SPAN_X))
               && ({1'b0, act_y} >= {1'b0, sh_y[i]})
               && ({1'b0, act_y} <  ({1'b0, sh_y[i]} + SPAN_Y));
    end
  end

`ifdef MULTI_WIN_BORDER_EN
  always_comb begin
    ring = '0;
    for (int i = 0; i < NUM_WIN; i++) begin
      ring[i] = ({1'b0, act_x} == {1'b0, sh_x[i]})
                || ({1'b0, act_x} == ({1'b0, sh_x[i]} + LAST_X))
                || ({1'b0, act_y} == {1'b0, sh_y[i]})
                || ({1'b0, act_y} == ({1'b0, sh_y[i]} + LAST_Y));
    end
  end
`endif

  // Scan from the highest index down so the lowest-index hit wins.
  always_comb begin
    sel_hit  = 1'b0;
    sel_mode = '0;
    sel_addr = '0;
`ifdef MULTI_WIN_BORDER_EN
    sel_ring = 1'b0;
`endif
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_hit  = 1'b1;
        sel_mode = sh_mode[i];
        sel_addr = ADDR_BITS'(i * PIC_N) + ADDR_BITS'(cnt[i]);
`ifdef MULTI_WIN_BORDER_EN
        sel_ring = ring[i];
`endif
      end
    end
  end

  // Occluded windows still advance so their images stay aligned when uncovered.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WIN; i++) cnt[i] <= '0;
    end else if (vs_rise) begin
      for (int i = 0; i < NUM_WIN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WIN; i++) begin
        if (hit[i]) cnt[i] <= (cnt[i] == CNT_LAST) ? '0 : cnt[i] + 1'b1;
      end
    end
  end

  // Address register plus a side pipeline whose last stage lines up with rom_data.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      for (int k = 0; k <= ROM_LAT; k++) begin
        s_hit[k]  <= 1'b0;
        s_mode[k] <= '0;
`ifdef MULTI_WIN_BORDER_EN
        s_ring[k] <= 1'b0;
`endif
      end
    end else begin
      rom_addr  <= sel_hit ? sel_addr : '0;
      s_hit[0]  <= sel_hit;
      s_mode[0] <= sel_mode;
`ifdef MULTI_WIN_BORDER_EN
      s_ring[0] <= sel_hit && sel_ring;
`endif
      for (int k = 1; k <= ROM_LAT; k++) begin
        s_hit[k]  <= s_hit[k-1];
        s_mode[k] <= s_mode[k-1];
`ifdef MULTI_WIN_BORDER_EN
        s_ring[k] <= s_ring[k-1];
`endif
      end
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      p1_hit  <= 1'b0;
      p1_mode <= '0;
      p1_data <= '0;
      p1_r    <= '0;
      p1_g    <= '0;
      p1_b    <= '0;
`ifdef MULTI_WIN_BORDER_EN
      p1_ring <= 1'b0;
`endif
    end else begin
      p1_hit  <= s_hit[ROM_LAT];
      p1_mode <= s_mode[ROM_LAT];
      p1_data <= rom_data;
      p1_r    <= (COLOR_DEPTH+8)'(rom_data[PIX_W-1 -: COLOR_DEPTH]) * (COLOR_DEPTH+8)'(77);
      p1_g    <= (COLOR_DEPTH+8)'(rom_data[2*COLOR_DEPTH-1 -: COLOR_DEPTH]) * (COLOR_DEPTH+8)'(150);
      p1_b    <= (COLOR_DEPTH+8)'(rom_data[COLOR_DEPTH-1:0]) * (COLOR_DEPTH+8)'(29);
`ifdef MULTI_WIN_BORDER_EN
      p1_ring <= s_ring[ROM_LAT];
`endif
    end
  end

  // Coefficients sum to 256, so the weighted sum fits in COLOR_DEPTH+8 bits.
  always_comb begin
    luma_sum = p1_r + p1_g + p1_b;
    luma     = COLOR_DEPTH'(luma_sum >> 8);
    case (p1_mode)
      2'd0:    proc_pix = p1_data;
      2'd1:    proc_pix = {luma, luma, luma};
      2'd2:    proc_pix = ~p1_data;
      default: proc_pix = (luma >= sh_thresh) ? '1 : '0;
    endcase
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      pixel_data <= BACK_COLOR;
    end else begin
`ifdef MULTI_WIN_BORDER_EN
      if (p1_hit && p1_ring) pixel_data <= BORDER_COLOR;
      else                   pixel_data <= p1_hit ? proc_pix : BACK_COLOR;
`else
      pixel_data <= p1_hit ? proc_pix : BACK_COLOR;
`endif
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) sync_pipe[k] <= '0;
    end else begin
      sync_pipe[0] <= {vs_in, hs_in, de_in};
      for (int k = 1; k < LAT; k++) sync_pipe[k] <= sync_pipe[k-1];
    end
  end

  assign {vs_out, hs_out, de_out} = sync_pipe[LAT-1];

endmodule

// File: tb/tb_multi_window_display.sv
// Self-checking bench for multi_window_display: frame-level model plus literal spot checks.
// Images are shrunk to 16x16 so every window can be scanned completely in a short run.
module tb_multi_window_display;

  localparam int XB  = 12;
  localparam int YB  = 12;
  localparam int NW  = 2;
  localparam int PW  = 16;
  localparam int PH  = 16;
  localparam int AB  = 18;
  localparam int RL  = 1;
  localparam int LAT = RL + 3;
  localparam int N   = PW * PH;
  localparam logic [23:0] BACK   = 24'hE0FFFF;
  localparam logic [23:0] BORDER = 24'hFF0000;
`ifdef MULTI_WIN_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic           pix_clk;
  logic           rst;
  logic [XB-1:0]  act_x;
  logic [YB-1:0]  act_y;
  logic           vs_in, hs_in, de_in;
  logic [NW*XB-1:0] win_x;
  logic [NW*YB-1:0] win_y;
  logic [NW-1:0]  win_en;
  logic [NW*2-1:0] win_mode;
  logic [7:0]     thresh;
  logic [AB-1:0]  rom_addr;
  logic [23:0]    rom_data;
  logic           vs_out, hs_out, de_out;
  logic [23:0]    pixel_data;

  int checks = 0;
  int failures = 0;

  multi_window_display #(
    .PIC_W(PW), .PIC_H(PH), .ROM_LAT(RL)
  ) dut (
    .pix_clk(pix_clk), .rst(rst),
    .act_x(act_x), .act_y(act_y),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .win_x(win_x), .win_y(win_y), .win_en(win_en), .win_mode(win_mode),
    .thresh(thresh),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .pixel_data(pixel_data)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  // External ROM: either returns its own address or a fixed colour.
  bit          rom_const_en = 1'b0;
  logic [23:0] rom_const = 24'h0;
  logic [23:0] rom_pipe [RL];
  always @(posedge pix_clk) begin
    rom_pipe[0] <= rom_const_en ? rom_const : {6'd0, rom_addr};
    for (int k = 1; k < RL; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_data = rom_pipe[RL-1];

  typedef struct packed {
    logic [23:0] pix;
    logic vs, hs, de;
  } exp_t;
  exp_t exp_q [$];

  int m_x [NW];
  int m_y [NW];
  int m_mode [NW];
  int m_cnt [NW];
  bit m_en [NW];
  int m_thr;
  bit m_vs_prev;

  function automatic logic [23:0] rom_model(input int a);
    return rom_const_en ? rom_const : 24'(a);
  endfunction

  function automatic logic [23:0] apply_mode(input logic [23:0] d, input int mode, input int thr);
    int r, g, b, y;
    r = int'(d[23:16]);
    g = int'(d[15:8]);
    b = int'(d[7:0]);
    y = (r * 77 + g * 150 + b * 29) / 256;
    case (mode)
      0: return d;
      1: return {y[7:0], y[7:0], y[7:0]};
      2: return ~d;
      default: return (y >= thr) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] lit(input logic [23:0] v, input bit ring);
    return (ring && BORDER_ON) ? BORDER : v;
  endfunction

  // Frame-level model: evaluates each input pixel in the order it was presented.
  exp_t e;
  bit   found;
  bit   h;
  bit   rg;
  int   px, py;
  always @(posedge pix_clk) begin
    if (rst) begin
      exp_q.delete();
      m_vs_prev = 1'b0;
      m_thr = 0;
      for (int i = 0; i < NW; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_mode[i] = 0; m_cnt[i] = 0; m_en[i] = 1'b0;
      end
    end else begin
      px = int'(act_x);
      py = int'(act_y);
      found = 1'b0;
      e.pix = BACK;
      for (int i = 0; i < NW; i++) begin
        h = m_en[i] && de_in && px >= m_x[i] && px < m_x[i] + PW && py >= m_y[i] && py < m_y[i] + PH;
        if (h) begin
          if (!found) begin
            found = 1'b1;
            rg = (px == m_x[i]) || (px == m_x[i] + PW - 1) || (py == m_y[i]) || (py == m_y[i] + PH - 1);
            e.pix = lit(apply_mode(rom_model(i * N + m_cnt[i]), m_mode[i], m_thr), rg);
          end
          m_cnt[i] = (m_cnt[i] + 1) % N;
        end
      end
      e.vs = vs_in;
      e.hs = hs_in;
      e.de = de_in;
      if (vs_in && !m_vs_prev) begin
        m_thr = int'(thresh);
        for (int i = 0; i < NW; i++) begin
          m_x[i]    = int'(win_x[i*XB +: XB]);
          m_y[i]    = int'(win_y[i*YB +: YB]);
          m_en[i]   = win_en[i];
          m_mode[i] = int'(win_mode[i*2 +: 2]);
          m_cnt[i]  = 0;
        end
      end
      m_vs_prev = vs_in;
      exp_q.push_back(e);
    end
  end

  exp_t c;
  always @(negedge pix_clk) begin
    if (!rst && exp_q.size() >= LAT) begin
      c = exp_q.pop_front();
      checks++;
      if (pixel_data !== c.pix || vs_out !== c.vs || hs_out !== c.hs || de_out !== c.de) begin
        failures++;
        $display("[TB] FAIL stream t=%0t got pix=%h vs/hs/de=%b%b%b expected pix=%h vs/hs/de=%b%b%b",
                 $time, pixel_data, vs_out, hs_out, de_out, c.pix, c.vs, c.hs, c.de);
      end
    end
  end

  bit watch_addr = 1'b0;
  int nz_addr = 0;
  always @(negedge pix_clk) if (watch_addr && rom_addr !== '0) nz_addr++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input bit de, input bit vs, input bit hs);
    @(posedge pix_clk);
    #1;
    act_x = XB'(x);
    act_y = YB'(y);
    de_in = de;
    vs_in = vs;
    hs_in = hs;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic newFrame();
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1);
    idle(LAT + 2);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic setWin(input int i, input int x, input int y, input bit en, input int mode);
    win_x[i*XB +: XB] = XB'(x);
    win_y[i*YB +: YB] = YB'(y);
    win_en[i] = en;
    win_mode[i*2 +: 2] = 2'(mode);
  endtask

  // Presents one pixel, then idles; returns the address it produced and its output pixel.
  task automatic probe(input int x, input int y, output logic [23:0] pix, output logic [AB-1:0] addr);
    applyStimulus(x, y, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
    addr = rom_addr;
    repeat (LAT - 1) @(posedge pix_clk);
    @(negedge pix_clk);
    pix = pixel_data;
  endtask

  logic [23:0]   pv;
  logic [AB-1:0] av;

  initial begin
    rst = 1'b1;
    act_x = '0; act_y = '0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
    win_x = '0; win_y = '0; win_en = '0; win_mode = '0; thresh = '0;
    repeat (3) @(posedge pix_clk);
    @(negedge pix_clk);
    checkOutput("reset_pixel", 32'(pixel_data), 32'(BACK));
    checkOutput("reset_syncs", {29'd0, vs_out, hs_out, de_out}, 32'd0);
    checkOutput("reset_addr", 32'(rom_addr), 32'd0);
    @(posedge pix_clk);
    #1 rst = 1'b0;

    $display("[TB] frame with all windows disabled");
    setWin(0, 640, 412, 1'b0, 0);
    setWin(1, 800, 100, 1'b0, 0);
    newFrame();
    watch_addr = 1'b1;
    for (int y = 410; y <= 414; y++)
      for (int x = 636; x <= 660; x++) applyStimulus(x, y, 1'b1, 1'b0, 1'b0);
    idle(LAT + 2);
    applyStimulus(5, 5, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
    repeat (LAT - 2) @(posedge pix_clk);
    @(negedge pix_clk);
    checkOutput("de_before_lat", 32'(de_out), 32'd0);
    @(negedge pix_clk);
    checkOutput("de_at_lat", 32'(de_out), 32'd1);
    checkOutput("bg_disabled", 32'(pixel_data), 32'(BACK));
    @(negedge pix_clk);
    checkOutput("de_after_lat", 32'(de_out), 32'd0);
    watch_addr = 1'b0;
    checkOutput("rom_addr_idle", 32'(nz_addr), 32'd0);

    $display("[TB] window 0 raw scan");
    setWin(0, 640, 412, 1'b1, 0);
    newFrame();
    probe(639, 412, pv, av);
    checkOutput("left_of_win_pix", 32'(pv), 32'(BACK));
    checkOutput("left_of_win_addr", 32'(av), 32'd0);
    probe(640, 412, pv, av);
    checkOutput("win0_first_pix", 32'(pv), 32'(lit(24'd0, 1'b1)));
    checkOutput("win0_first_addr", 32'(av), 32'd0);
    for (int y = 412; y < 412 + PH; y++)
      for (int x = 640; x < 640 + PW; x++) begin
        if (x == 640 && y == 412) continue;
        if (x == 640 + PW - 1 && y == 412 + PH - 1) begin
          probe(x, y, pv, av);
          checkOutput("win0_last_pix", 32'(pv), 32'(lit(24'd255, 1'b1)));
          checkOutput("win0_last_addr", 32'(av), 32'd255);
        end else begin
          applyStimulus(x, y, 1'b1, 1'b0, 1'b0);
        end
      end

    $display("[TB] window 1 pixel modes");
    rom_const_en = 1'b1;
    rom_const = 24'hFF0000;
    setWin(0, 640, 412, 1'b0, 0);
    setWin(1, 800, 100, 1'b1, 1);
    newFrame();
    probe(801, 101, pv, av);
    checkOutput("mode_grey", 32'(pv), 32'h4C4C4C);
    checkOutput("win1_base_addr", 32'(av), 32'd256);
    setWin(1, 800, 100, 1'b1, 2);
    newFrame();
    probe(801, 101, pv, av);
    checkOutput("mode_invert", 32'(pv), 32'h00FFFF);
    setWin(1, 800, 100, 1'b1, 3);
    thresh = 8'h50;
    newFrame();
    probe(801, 101, pv, av);
    checkOutput("mode_thresh_above", 32'(pv), 32'h000000);
    thresh = 8'h4C;
    newFrame();
    probe(801, 101, pv, av);
    checkOutput("mode_thresh_equal", 32'(pv), 32'hFFFFFF);

    $display("[TB] overlapping windows");
    rom_const_en = 1'b0;
    thresh = 8'h00;
    setWin(0, 100, 100, 1'b1, 0);
    setWin(1, 108, 100, 1'b1, 0);
    newFrame();
    for (int x = 100; x < 124; x++) begin
      if (x == 108) begin
        probe(x, 100, pv, av);
        checkOutput("overlap_win0_shown", 32'(pv), 32'(lit(24'd8, 1'b1)));
      end else if (x == 116) begin
        probe(x, 100, pv, av);
        checkOutput("occluded_cnt_advanced", 32'(pv), 32'(lit(24'd264, 1'b1)));
      end else begin
        applyStimulus(x, 100, 1'b1, 1'b0, 1'b0);
      end
    end

    $display("[TB] identical windows");
    setWin(1, 100, 100, 1'b1, 0);
    newFrame();
    probe(100, 100, pv, av);
    checkOutput("identical_pix", 32'(pv), 32'(lit(24'd0, 1'b1)));
    checkOutput("identical_addr", 32'(av), 32'd0);
    for (int y = 100; y < 100 + PH; y++)
      for (int x = 100; x < 100 + PW; x++)
        if (!(x == 100 && y == 100)) applyStimulus(x, y, 1'b1, 1'b0, 1'b0);
    setWin(1, 300, 100, 1'b1, 0);
    newFrame();
    probe(300, 100, pv, av);
    checkOutput("moved_win1_pix", 32'(pv), 32'(lit(24'd256, 1'b1)));
    checkOutput("moved_win1_addr", 32'(av), 32'd256);

    $display("[TB] mid-frame config change");
    setWin(0, 640, 412, 1'b1, 0);
    setWin(1, 300, 100, 1'b0, 0);
    newFrame();
    probe(640, 412, pv, av);
    checkOutput("midframe_before", 32'(pv), 32'(lit(24'd0, 1'b1)));
    setWin(0, 700, 412, 1'b1, 0);
    probe(641, 412, pv, av);
    checkOutput("midframe_unchanged", 32'(pv), 32'(lit(24'd1, 1'b1)));
    newFrame();
    probe(640, 412, pv, av);
    checkOutput("nextframe_old_pos", 32'(pv), 32'(BACK));
    probe(700, 412, pv, av);
    checkOutput("nextframe_new_pos", 32'(pv), 32'(lit(24'd0, 1'b1)));

    $display("[TB] reset mid-line");
    applyStimulus(701, 412, 1'b1, 1'b0, 1'b0);
    applyStimulus(702, 412, 1'b1, 1'b0, 1'b0);
    @(posedge pix_clk);
    #1 rst = 1'b1;
    de_in = 1'b0;
    #1;
    checkOutput("midreset_pixel", 32'(pixel_data), 32'(BACK));
    checkOutput("midreset_de", 32'(de_out), 32'd0);
    checkOutput("midreset_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(posedge pix_clk);
    #1 rst = 1'b0;
    probe(703, 412, pv, av);
    checkOutput("after_reset_bg", 32'(pv), 32'(BACK));
    newFrame();
    probe(700, 412, pv, av);
    checkOutput("after_reset_vs", 32'(pv), 32'(lit(24'd0, 1'b1)));

`ifdef MULTI_WIN_BORDER_EN
    $display("[TB] border ring");
    setWin(0, 10, 10, 1'b1, 0);
    newFrame();
    probe(10, 10, pv, av);
    checkOutput("border_corner", 32'(pv), 32'(BORDER));
    probe(11, 10, pv, av);
    checkOutput("border_top", 32'(pv), 32'(BORDER));
    applyStimulus(10, 11, 1'b1, 1'b0, 1'b0);
    probe(11, 11, pv, av);
    checkOutput("border_interior", 32'(pv), 32'd3);
`endif

    idle(LAT + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
